// File: rtl/bird_control_if.sv
// Command/feedback bundle between the bird sequencing controller and its surroundings.
// master = the controller, slave = datapath/gun/game side.
interface bird_control_if;
  logic       start;
  logic       shoot;
  logic [7:0] aim_x;
  logic [6:0] aim_y;
  logic [7:0] bird_x;
  logic [6:0] bird_y;
  logic       enable;
  logic [3:0] control;
  logic [1:0] bird_state;
  logic       hit_pulse;
  logic       escape_pulse;

  modport master (
    input  start, shoot, aim_x, aim_y, bird_x, bird_y, enable,
    output control, bird_state, hit_pulse, escape_pulse
  );

  modport slave (
    output start, shoot, aim_x, aim_y, bird_x, bird_y, enable,
    input  control, bird_state, hit_pulse, escape_pulse
  );
endinterface

// File: rtl/bird_control.sv
// Bird sequencing controller: frame pacing, clear/move/draw handshake, shot and escape endings.
// Define BIRD_CTRL_LFSR_EN for LFSR-driven direction; otherwise direction alternates right/up.
module bird_control #(
  parameter int FRAME_DIV     = 833333,
  parameter int ESCAPE_FRAMES = 600,
  parameter int MAX_X         = 156,
  parameter int MAX_Y         = 116
) (
  input logic            clk,
  input logic            reset_n,
  bird_control_if.master bus
);

  localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int ESC_W = (ESCAPE_FRAMES > 0) ? $clog2(ESCAPE_FRAMES + 1) : 1;
  localparam logic [ESC_W-1:0] ESC_MAX = ESC_W'(ESCAPE_FRAMES);

  localparam logic [3:0] C_IDLE  = 4'b0000;
  localparam logic [3:0] C_LEFT  = 4'b0001;
  localparam logic [3:0] C_RIGHT = 4'b0010;
  localparam logic [3:0] C_UP    = 4'b0011;
  localparam logic [3:0] C_DOWN  = 4'b0100;
  localparam logic [3:0] C_CLEAR = 4'b0101;
  localparam logic [3:0] C_DRAW  = 4'b0110;
  localparam logic [3:0] C_SHOT  = 4'b0111;
  localparam logic [3:0] C_ESC   = 4'b1000;

  localparam logic [1:0] B_FLY  = 2'b00;
  localparam logic [1:0] B_FALL = 2'b01;
  localparam logic [1:0] B_ESC  = 2'b10;
  localparam logic [1:0] B_DONE = 2'b11;

  typedef enum logic [2:0] {
    S_WAIT, S_CLEAR, S_MOVE, S_DRAW, S_FALL, S_ESCAPE, S_DONE
  } state_t;

  state_t           r_state;
  logic [3:0]       r_control;
  logic [1:0]       r_bird_state;
  logic             r_hit_pulse;
  logic             r_esc_pulse;
  logic [ESC_W-1:0] r_esc_cnt;
  logic             r_shot;
  logic [CNT_W-1:0] r_frame_cnt;

  logic       w_tick;
  logic       w_flying;
  logic       w_in_box;
  logic       w_move_go;
  logic [7:0] w_dx;
  logic [6:0] w_dy;
  logic [1:0] w_dir_sel;
  logic [3:0] w_dir;

  assign w_tick    = (r_frame_cnt == CNT_W'(FRAME_DIV - 1));
  assign w_move_go = (r_state == S_CLEAR) && bus.enable;
  assign w_flying  = (r_state == S_WAIT) || (r_state == S_CLEAR) ||
                     (r_state == S_MOVE) || (r_state == S_DRAW);

  // Modular differences: a crosshair left of/above the bird wraps large and misses.
  assign w_dx     = bus.aim_x - bus.bird_x;
  assign w_dy     = bus.aim_y - bus.bird_y;
  assign w_in_box = (w_dx <= 8'd3) && (w_dy <= 7'd3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_cnt <= '0;
    end else if (w_tick) begin
      r_frame_cnt <= '0;
    end else begin
      r_frame_cnt <= r_frame_cnt + CNT_W'(1);
    end
  end

`ifdef BIRD_CTRL_LFSR_EN
  logic [7:0] r_lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= 8'hA5;
    end else if (w_tick) begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_dir_sel = r_lfsr[1:0];
`else
  logic r_alt;

  // Bring-up path: right on even moves, up on odd moves.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alt <= 1'b0;
    end else if (w_move_go) begin
      r_alt <= ~r_alt;
    end
  end

  assign w_dir_sel = r_alt ? 2'b10 : 2'b01;
`endif

  always_comb begin
    w_dir = C_IDLE;
    case (w_dir_sel)
      2'b00:   w_dir = (bus.bird_x == 8'd0)          ? C_RIGHT : C_LEFT;
      2'b01:   w_dir = (bus.bird_x >= 8'(MAX_X))     ? C_LEFT  : C_RIGHT;
      2'b10:   w_dir = (bus.bird_y == 7'd0)          ? C_DOWN  : C_UP;
      default: w_dir = (bus.bird_y >= 7'(MAX_Y))     ? C_UP    : C_DOWN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_WAIT;
      r_control    <= C_IDLE;
      r_bird_state <= B_FLY;
      r_hit_pulse  <= 1'b0;
      r_esc_pulse  <= 1'b0;
      r_esc_cnt    <= '0;
      r_shot       <= 1'b0;
    end else begin
      r_hit_pulse <= 1'b0;
      r_esc_pulse <= 1'b0;
      if (w_flying && bus.shoot && w_in_box) begin
        r_shot <= 1'b1;
      end
      case (r_state)
        S_WAIT: begin
          // A pending hit outranks an escape that falls due in the same cycle.
          if (r_shot) begin
            r_state      <= S_FALL;
            r_control    <= C_SHOT;
            r_bird_state <= B_FALL;
            r_shot       <= 1'b0;
          end else if (r_esc_cnt == ESC_MAX) begin
            r_state      <= S_ESCAPE;
            r_control    <= C_ESC;
            r_bird_state <= B_ESC;
          end else if (w_tick) begin
            r_state   <= S_CLEAR;
            r_control <= C_CLEAR;
          end
        end
        S_CLEAR: begin
          if (bus.enable) begin
            r_state   <= S_MOVE;
            r_control <= w_dir;
          end
        end
        S_MOVE: begin
          r_state   <= S_DRAW;
          r_control <= C_DRAW;
        end
        S_DRAW: begin
          if (bus.enable) begin
            r_state   <= S_WAIT;
            r_control <= C_IDLE;
            if (r_esc_cnt != ESC_MAX) begin
              r_esc_cnt <= r_esc_cnt + ESC_W'(1);
            end
          end
        end
        S_FALL: begin
          if (w_tick && (bus.bird_y >= 7'(MAX_Y))) begin
            r_state      <= S_DONE;
            r_control    <= C_IDLE;
            r_bird_state <= B_DONE;
            r_hit_pulse  <= 1'b1;
          end
        end
        S_ESCAPE: begin
          if (w_tick && (bus.bird_y == 7'd0)) begin
            r_state      <= S_DONE;
            r_control    <= C_IDLE;
            r_bird_state <= B_DONE;
            r_esc_pulse  <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.start) begin
            r_state      <= S_WAIT;
            r_control    <= C_IDLE;
            r_bird_state <= B_FLY;
            r_esc_cnt    <= '0;
            r_shot       <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_WAIT;
          r_control <= C_IDLE;
        end
      endcase
    end
  end

  assign bus.control      = r_control;
  assign bus.bird_state   = r_bird_state;
  assign bus.hit_pulse    = r_hit_pulse;
  assign bus.escape_pulse = r_esc_pulse;

endmodule
